// File: rtl/led_bar_controller.sv
// LED bar level controller: three debounced push-buttons step a 0..CNT_MAX bar
// level by hand, or let it bounce between the ends automatically.
module led_bar_controller #(
    parameter int CNT_MAX   = 16,
    parameter int TICK_DIV  = 50_000_000,
    parameter int DB_CYCLES = 500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_mode,
    output logic [4:0] counter_out,
    output logic       auto_mode,
    output logic       dir_up
);
    localparam int PS_W = $clog2(TICK_DIV);
    localparam int DB_W = $clog2(DB_CYCLES + 1);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [4:0]      LVL_MAX = 5'(CNT_MAX);

    typedef enum logic [1:0] {MANUAL, AUTO_UP, AUTO_DOWN} state_t;

    function automatic logic [4:0] sat_inc(input logic [4:0] v);
        return (v < LVL_MAX) ? v + 5'd1 : LVL_MAX;
    endfunction

    function automatic logic [4:0] sat_dec(input logic [4:0] v);
        return (v != 5'd0) ? v - 5'd1 : 5'd0;
    endfunction

    // Bit order in the button vectors: [0]=up, [1]=down, [2]=mode.
    logic [2:0]            r_sync1;
    logic [2:0]            r_sync2;
    logic [2:0]            r_db;
    logic [2:0]            r_db_d;
    logic [2:0]            r_press;
    logic [2:0][DB_W-1:0]  r_db_cnt;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [4:0]      w_cnt_nxt;
    logic [PS_W-1:0] r_ps;
    logic [PS_W-1:0] w_ps_nxt;
    logic            w_tick;
    logic            w_up;
    logic            w_down;
    logic            w_mode;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_db     <= '0;
            r_db_d   <= '0;
            r_press  <= '0;
            r_db_cnt <= '0;
        end else begin
            r_sync1 <= {btn_mode, btn_down, btn_up};
            r_sync2 <= r_sync1;
            r_db_d  <= r_db;
            r_press <= r_db & ~r_db_d;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_db[i]     <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign w_up   = r_press[0];
    assign w_down = r_press[1];
    assign w_mode = r_press[2];
    assign w_tick = (r_ps == PS_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = counter_out;
        w_ps_nxt    = '0;
        unique case (r_state)
            MANUAL: begin
                if (w_mode) begin
                    w_state_nxt = (counter_out < LVL_MAX) ? AUTO_UP : AUTO_DOWN;
                end else if (w_up && !w_down) begin
                    w_cnt_nxt = sat_inc(counter_out);
                end else if (w_down && !w_up) begin
                    w_cnt_nxt = sat_dec(counter_out);
                end
            end
            AUTO_UP: begin
                if (w_mode) begin
                    w_state_nxt = MANUAL;
                end else begin
                    w_ps_nxt = w_tick ? '0 : r_ps + PS_W'(1);
                    if (w_tick) begin
                        w_cnt_nxt = sat_inc(counter_out);
                        // Turn around on the same edge that reaches the top.
                        if (sat_inc(counter_out) == LVL_MAX) w_state_nxt = AUTO_DOWN;
                    end
                end
            end
            AUTO_DOWN: begin
                if (w_mode) begin
                    w_state_nxt = MANUAL;
                end else begin
                    w_ps_nxt = w_tick ? '0 : r_ps + PS_W'(1);
                    if (w_tick) begin
                        w_cnt_nxt = sat_dec(counter_out);
                        if (sat_dec(counter_out) == 5'd0) w_state_nxt = AUTO_UP;
                    end
                end
            end
            default: w_state_nxt = MANUAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= MANUAL;
            r_ps        <= '0;
            counter_out <= 5'd0;
            auto_mode   <= 1'b0;
            dir_up      <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_ps        <= w_ps_nxt;
            counter_out <= w_cnt_nxt;
            auto_mode   <= (w_state_nxt != MANUAL);
            dir_up      <= (w_state_nxt != AUTO_DOWN);
        end
    end
endmodule

// File: tb/tb_led_bar_controller.sv
// Bench for led_bar_controller: directed and random button activity checked
// against a level/bounce model derived from the button and auto-step rules.
module tb_led_bar_controller;
    localparam int CNT_MAX   = 16;
    localparam int TICK_DIV  = 4;
    localparam int DB_CYCLES = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_up;
    logic       btn_down;
    logic       btn_mode;
    logic [4:0] counter_out;
    logic       auto_mode;
    logic       dir_up;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int hold_up = 0;
    int hold_dn = 0;
    int hold_md = 0;
    int lvl = 0;

    led_bar_controller #(
        .CNT_MAX  (CNT_MAX),
        .TICK_DIV (TICK_DIV),
        .DB_CYCLES(DB_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_mode   (btn_mode),
        .counter_out(counter_out),
        .auto_mode  (auto_mode),
        .dir_up     (dir_up)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: sample point is the falling edge; timed button releases happen here.
    task automatic step();
        @(negedge clk);
        if (hold_up > 0) begin hold_up--; if (hold_up == 0) btn_up = 1'b0; end
        if (hold_dn > 0) begin hold_dn--; if (hold_dn == 0) btn_down = 1'b0; end
        if (hold_md > 0) begin hold_md--; if (hold_md == 0) btn_mode = 1'b0; end
    endtask

    // Auto bounce after k steps from level l0 heading up0.
    function automatic void auto_model(input int l0, input bit up0, input int k,
                                       output int l, output bit up);
        l  = l0;
        up = up0;
        for (int i = 0; i < k; i++) begin
            if (up) begin l++; if (l == CNT_MAX) up = 1'b0; end
            else    begin l--; if (l == 0)       up = 1'b1; end
        end
    endfunction

    // which: 0 = up, 1 = down, 2 = both together; clean 8-cycle press then 8 low.
    task automatic press(input int which);
        if (which != 1) begin btn_up = 1'b1; hold_up = 8; end
        if (which != 0) begin btn_down = 1'b1; hold_dn = 8; end
        repeat (16) step();
        if (which == 0) lvl = (lvl < CNT_MAX) ? lvl + 1 : CNT_MAX;
        if (which == 1) lvl = (lvl > 0) ? lvl - 1 : 0;
        check("manual_level", counter_out, lvl);
    endtask

    task automatic set_level(input int t);
        for (int i = 0; i < 40 && lvl < t; i++) press(0);
        for (int i = 0; i < 40 && lvl > t; i++) press(1);
    endtask

    task automatic run_auto(input int dur_in, input int exit_edge, input bit noise,
                            output int t0, output int t1);
        int n_r, lat, dur, l, k;
        bit d, up0, seen;
        up0 = (lvl < CNT_MAX);
        t0 = 0; t1 = 0; seen = 1'b0;
        btn_mode = 1'b1; hold_md = 8; n_r = cyc;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (auto_mode === 1'b1) begin seen = 1'b1; t0 = cyc; end
        end
        check("auto_entry", seen, 1);
        if (!seen) return;
        lat = t0 - n_r;
        check("press_latency_in_range", (lat >= DB_CYCLES + 3 && lat <= DB_CYCLES + 5), 1);
        check("entry_level", counter_out, lvl);
        check("entry_dir", dir_up, up0);
        dur = (exit_edge > 0) ? exit_edge - lat : dur_in;
        for (int i = 0; i < dur; i++) begin
            step();
            if (noise && i + 16 < dur && hold_up == 0 && hold_dn == 0 && $urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 1) == 1) begin btn_up = 1'b1; hold_up = 8; end
                else begin btn_down = 1'b1; hold_dn = 8; end
            end
            k = (cyc - t0) / TICK_DIV;
            auto_model(lvl, up0, k, l, d);
            check("auto_level", counter_out, l);
            check("auto_dir", dir_up, d);
            check("auto_flag", auto_mode, 1);
        end
        btn_mode = 1'b1; hold_md = 8; seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (auto_mode === 1'b0) begin
                seen = 1'b1; t1 = cyc;
            end else begin
                k = (cyc - t0) / TICK_DIV;
                auto_model(lvl, up0, k, l, d);
                check("auto_level_exit_wait", counter_out, l);
            end
        end
        check("auto_exit", seen, 1);
        k = (t1 - 1 - t0) / TICK_DIV;
        auto_model(lvl, up0, k, l, d);
        check("exit_level", counter_out, l);
        check("exit_dir_up", dir_up, 1);
        lvl = l;
        repeat (16) step();
        check("post_exit_hold", counter_out, lvl);
        check("post_exit_manual", auto_mode, 0);
    endtask

    initial begin
        int t0, t1, op, w;
        bit seen;
        rst = 1'b1;
        btn_up   = 1'($urandom_range(0, 1));
        btn_down = 1'($urandom_range(0, 1));
        btn_mode = 1'($urandom_range(0, 1));
        step();
        check("rst_counter", counter_out, 0);
        check("rst_auto", auto_mode, 0);
        check("rst_dir", dir_up, 1);
        btn_up   = 1'($urandom_range(0, 1));
        btn_down = 1'($urandom_range(0, 1));
        btn_mode = 1'($urandom_range(0, 1));
        step();
        check("rst2_counter", counter_out, 0);
        check("rst2_auto", auto_mode, 0);
        rst = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_mode = 1'b0;
        repeat (12) step();
        check("idle_after_reset", counter_out, 0);
        lvl = 0;

        // Walk to the top and past it, then to the bottom and past it.
        for (int i = 0; i < 18; i++) press(0);
        check("top_saturated", counter_out, CNT_MAX);
        for (int i = 0; i < 18; i++) press(1);
        check("bottom_saturated", counter_out, 0);

        // Bouncing contact then a settled press gives exactly one step.
        btn_up = 1'b1;
        for (int i = 0; i < 10; i++) begin step(); btn_up = ~btn_up; end
        btn_up = 1'b1;
        repeat (10) step();
        btn_up = 1'b0;
        repeat (10) step();
        lvl = 1;
        check("bounce_single_step", counter_out, 1);

        // Button held through reset counts once after reset releases.
        btn_up = 1'b1;
        rst = 1'b1;
        repeat (3) step();
        check("held_rst_counter", counter_out, 0);
        rst = 1'b0;
        repeat (12) step();
        btn_up = 1'b0;
        repeat (10) step();
        lvl = 1;
        check("held_through_reset", counter_out, 1);

        // Auto from 14: up to the top, turn, come back down.
        set_level(14);
        run_auto(20, -1, 1'b0, t0, t1);

        // From the top in AUTO_DOWN, exit exactly on the tick that would leave 7.
        set_level(CNT_MAX);
        run_auto(0, 10 * TICK_DIV, 1'b0, t0, t1);
        check("coincident_exit_edge", t1 - t0, 10 * TICK_DIV);
        check("coincident_level", counter_out, 7);

        // Reset while auto-stepping upward at level 9.
        set_level(8);
        btn_mode = 1'b1; hold_md = 8; seen = 1'b0; t0 = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (auto_mode === 1'b1) begin seen = 1'b1; t0 = cyc; end
        end
        check("r29_entry", seen, 1);
        for (int i = 0; i < 10 && cyc < t0 + TICK_DIV + 1; i++) step();
        check("r29_level9", counter_out, 9);
        check("r29_dir", dir_up, 1);
        rst = 1'b1;
        step();
        check("r29_rst_counter", counter_out, 0);
        check("r29_rst_auto", auto_mode, 0);
        check("r29_rst_dir", dir_up, 1);
        rst = 1'b0;
        for (int i = 0; i < 24; i++) begin
            step();
            if (i % 6 == 5) begin
                check("r29_no_steps", counter_out, 0);
                check("r29_manual", auto_mode, 0);
            end
        end
        lvl = 0;

        // Random mix of presses, simultaneous presses, glitches and auto sessions.
        for (int it = 0; it < 30; it++) begin
            op = $urandom_range(0, 5);
            case (op)
                0, 1, 2: press(op);
                3: begin
                    w = $urandom_range(1, DB_CYCLES - 1);
                    if ($urandom_range(0, 1) == 1) btn_up = 1'b1; else btn_down = 1'b1;
                    repeat (w) step();
                    btn_up = 1'b0; btn_down = 1'b0;
                    repeat (14) step();
                    check("glitch_ignored", counter_out, lvl);
                end
                default: run_auto($urandom_range(16, 60), -1, 1'b1, t0, t1);
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/led_bar_controller.md
LED_BAR_CONTROLLER -- requirements
Module: led_bar_controller

Interface
REQ-001 SHALL have parameter CNT_MAX, default 16: top of the bar level (1..31).
REQ-002 SHALL have parameter TICK_DIV, default 50_000_000: clocks per auto step (>=2).
REQ-003 SHALL have parameter DB_CYCLES, default 500_000: clocks a raw button must stay stable to be accepted (>=1).
REQ-004 SHALL have port clk, input, 1: the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port btn_up, input, 1: raw, asynchronous, bouncing level; high = pressed.
REQ-007 SHALL have port btn_down, input, 1: raw level, same as btn_up.
REQ-008 SHALL have port btn_mode, input, 1: raw level, same as btn_up.
REQ-009 SHALL have port counter_out, output, 5: bar level 0..CNT_MAX, driven directly into the LED bar decoder.
REQ-010 SHALL have port auto_mode, output, 1: 1 when state is AUTO_UP or AUTO_DOWN.
REQ-011 SHALL have port dir_up, output, 1: 1 in AUTO_UP and MANUAL, 0 in AUTO_DOWN.

Function
REQ-012 SHALL pass each button through a 2-flop synchronizer, then a debouncer: a per-button counter counts consecutive cycles where the synchronized level differs from the debounced level, updates the debounced level at DB_CYCLES, and clears on any match.
REQ-013 SHALL generate a one-cycle press pulse per button on a 0->1 edge of its debounced level; a raw level that settles high SHALL give its pulse DB_CYCLES+2 to DB_CYCLES+4 clocks later, and a release SHALL give no pulse.
REQ-014 SHALL run a prescaler 0..TICK_DIV-1 only in AUTO states; tick = (prescaler==TICK_DIV-1), then wrap to 0; the prescaler SHALL be held at 0 in MANUAL, so the first auto step occurs TICK_DIV cycles after entering AUTO.
REQ-015 SHALL implement FSM states MANUAL, AUTO_UP, AUTO_DOWN; all outputs registered.
REQ-016 MANUAL: up pulse -> counter_out+1, saturating at CNT_MAX; down pulse -> counter_out-1, saturating at 0; up and down in the same cycle -> no change.
REQ-017 MANUAL: mode pulse -> AUTO_UP if counter_out<CNT_MAX, else AUTO_DOWN; counter_out unchanged in that cycle; mode takes priority over up/down in the same cycle.
REQ-018 AUTO_UP: tick -> counter_out+1; the step that writes CNT_MAX SHALL also switch to AUTO_DOWN on the same edge.
REQ-019 AUTO_DOWN: tick -> counter_out-1; the step that writes 0 SHALL also switch to AUTO_UP on the same edge.
REQ-020 AUTO states: up/down pulses SHALL be ignored; mode pulse -> MANUAL with counter_out retained; mode beats a coincident tick (step dropped).
REQ-021 counter_out SHALL never leave 0..CNT_MAX; a pulse changes counter_out on the edge after the pulse cycle (1-cycle latency).

Reset
REQ-022 rst high at a clock edge SHALL set, on that edge: counter_out=0, state MANUAL, auto_mode=0, dir_up=1, prescaler=0, debounce counters=0, debounced levels=0, synchronizer flops=0.
REQ-023 Reset mid-operation SHALL abort any auto step or pending pulse; a button held high through reset SHALL produce exactly one press after debounce once rst is low.

Verification (TICK_DIV=4, DB_CYCLES=3, CNT_MAX=16)
REQ-024 Random buttons with rst high for 2 cycles -> counter_out=0, auto_mode=0, dir_up=1 after the first reset edge.
REQ-025 18 clean btn_up presses -> counter_out 1..16 then holds at 16; 18 btn_down presses -> back to 0 and holds at 0.
REQ-026 btn_up toggling every cycle for 10 cycles, then high for 10 cycles -> exactly one increment (0->1).
REQ-027 counter_out=14, mode press -> auto_mode=1, dir_up=1; 15 at +4 cycles; 16 with dir_up=0 at +8; 15 at +12.
REQ-028 mode pulse in AUTO_DOWN on the same cycle as a tick, counter_out=7 -> MANUAL, counter_out stays 7, auto_mode=0, dir_up=1.
REQ-029 rst pulse in AUTO_UP at counter_out=9 -> next cycle counter_out=0 and MANUAL; no auto steps follow.
